// File: rtl/if_to_id.sv
// IF/ID pipeline register with load-use hazard detection and branch squash.
// Optional IF_TO_ID_STATS_EN adds stall_count/flush_count event counters.
module if_to_id #(
  parameter logic [31:0] NOP_INSTR    = 32'h00000013,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCIn,
  input  logic [31:0] InstrIn,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        ext_stall,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        valid,
  output logic        pc_write,
`ifdef IF_TO_ID_STATS_EN
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
`endif
  output logic        bubble
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        is_lui;
  logic        is_auipc;
  logic        is_jal;
  logic        is_reg;
  logic        is_store;
  logic        is_branch;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        hz;
  logic        hold;

  logic [2:0]  flush_cnt;
  logic [2:0]  flush_cnt_d;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;

  assign opcode    = Instr[6:0];
  assign rs1       = Instr[19:15];
  assign rs2       = Instr[24:20];

  assign is_lui    = (opcode == OP_LUI);
  assign is_auipc  = (opcode == OP_AUIPC);
  assign is_jal    = (opcode == OP_JAL);
  assign is_reg    = (opcode == OP_REG);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_jal: begin
        uses_rs1 = 1'b0;
      end
      is_reg, is_store, is_branch: begin
        uses_rs2 = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign rs1_hit = uses_rs1 & (ex_rd == rs1);
  assign rs2_hit = uses_rs2 & (ex_rd == rs2);

  // Squashed slots never stall: valid gates the whole compare.
  assign hz = valid & ex_memread & (ex_rd != 5'd0)
            & (rs1_hit | rs2_hit);

  assign hold = ext_stall | hz;

  // Reset forces the PC to advance so fetch restarts cleanly.
  assign pc_write = ~rst | branch_taken | ~hold;
  assign bubble   = ~rst | branch_taken | hold | ~valid;

  always_comb begin
    pc_d        = PC;
    instr_d     = Instr;
    valid_d     = valid;
    flush_cnt_d = flush_cnt;
    if (branch_taken) begin
      pc_d        = PCIn;
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      flush_cnt_d = FLUSH_RELOAD;
    end else if (hold) begin
      pc_d        = PC;
    end else if (flush_cnt != 3'd0) begin
      pc_d        = PCIn;
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      flush_cnt_d = flush_cnt - 3'd1;
    end else begin
      pc_d        = PCIn;
      instr_d     = InstrIn;
      valid_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC        <= 32'd0;
      Instr     <= NOP_INSTR;
      valid     <= 1'b0;
      flush_cnt <= 3'd0;
    end else begin
      PC        <= pc_d;
      Instr     <= instr_d;
      valid     <= valid_d;
      flush_cnt <= flush_cnt_d;
    end
  end

`ifdef IF_TO_ID_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= 32'd0;
      flush_count <= 32'd0;
    end else begin
      if (hz && !branch_taken) begin
        stall_count <= stall_count + 32'd1;
      end
      if (branch_taken) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_to_id.sv
// Scoreboard bench for if_to_id: randomized and directed stimulus
// against a slot-level reference model, checked by decoupled monitors.
module tb_if_to_id;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCIn;
  logic [31:0] InstrIn;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        branch_taken;
  logic        ext_stall;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        valid;
  logic        pc_write;
  logic        bubble;
`ifdef IF_TO_ID_STATS_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  always #5 clk = ~clk;

  if_to_id #(.NOP_INSTR(NOP), .FLUSH_CYCLES(FC)) dut (
    .clk(clk),
    .rst(rst),
    .PCIn(PCIn),
    .InstrIn(InstrIn),
    .ex_memread(ex_memread),
    .ex_rd(ex_rd),
    .branch_taken(branch_taken),
    .ext_stall(ext_stall),
    .PC(PC),
    .Instr(Instr),
    .valid(valid),
    .pc_write(pc_write),
`ifdef IF_TO_ID_STATS_EN
    .stall_count(stall_count),
    .flush_count(flush_count),
`endif
    .bubble(bubble)
  );

  typedef struct {
    logic        pw;
    logic        bb;
    logic [31:0] sc;
    logic [31:0] fc;
  } comb_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        v;
  } regs_t;

  comb_t comb_q[$];
  regs_t reg_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: the instruction slot held in ID
  logic [31:0] m_pc    = 32'd0;
  logic [31:0] m_instr = NOP;
  logic        m_v     = 1'b0;
  int          m_squash = 0;
  logic [31:0] m_sc    = 32'd0;
  logic [31:0] m_fc    = 32'd0;

  function automatic logic m_hz(logic v, logic [31:0] ins,
                                logic mr, logic [4:0] rd);
    logic [6:0] op;
    logic r1;
    logic r2;
    op = ins[6:0];
    r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    return v && mr && (rd != 5'd0)
        && ((r1 && ins[19:15] == rd) || (r2 && ins[24:20] == rd));
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s got %h want %h", name, act, exp);
  endtask

  task automatic step(input logic [31:0] pcin, input logic [31:0] ins,
                      input logic mr, input logic [4:0] rd,
                      input logic br, input logic st, input logic r);
    comb_t c;
    regs_t n;
    logic  h;
    @(negedge clk);
    rst = r; PCIn = pcin; InstrIn = ins;
    ex_memread = mr; ex_rd = rd;
    branch_taken = br; ext_stall = st;
    if (!r) begin
      m_pc = 32'd0; m_instr = NOP; m_v = 1'b0; m_squash = 0;
      m_sc = 32'd0; m_fc = 32'd0;
    end
    h = m_hz(m_v, m_instr, mr, rd);
    c.pw = !r || br || !(st || h);
    c.bb = !r || br || st || h || !m_v;
    c.sc = m_sc;
    c.fc = m_fc;
    comb_q.push_back(c);
    if (r) begin
      if (h && !br) m_sc++;
      if (br) m_fc++;
      if (br) begin
        m_pc = pcin; m_instr = NOP; m_v = 1'b0; m_squash = FC - 1;
      end else if (st || h) begin
        m_pc = m_pc;
      end else if (m_squash > 0) begin
        m_pc = pcin; m_instr = NOP; m_v = 1'b0; m_squash--;
      end else begin
        m_pc = pcin; m_instr = ins; m_v = 1'b1;
      end
    end
    n.pc = m_pc; n.instr = m_instr; n.v = m_v;
    reg_q.push_back(n);
  endtask

  initial begin : comb_mon
    comb_t c;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        check("pc_write", 32'(pc_write), 32'(c.pw));
        check("bubble", 32'(bubble), 32'(c.bb));
`ifdef IF_TO_ID_STATS_EN
        check("stall_count", stall_count, c.sc);
        check("flush_count", flush_count, c.fc);
`endif
      end
    end
  end

  initial begin : reg_mon
    regs_t n;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        n = reg_q.pop_front();
        check("PC", PC, n.pc);
        check("Instr", Instr, n.instr);
        check("valid", 32'(valid), 32'(n.v));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LUI = 32'h000010B7;
  localparam logic [31:0] ADI = 32'h00500093;

  logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011,
                           7'b0100011, 7'b1100011, 7'b0110111,
                           7'b0010111, 7'b1101111, 7'b1100111,
                           7'b1110011};

  initial begin : driver
    logic [31:0] ins;
    logic [31:0] pc;
    rst = 1'b0; PCIn = '0; InstrIn = '0;
    ex_memread = 1'b0; ex_rd = '0;
    branch_taken = 1'b0; ext_stall = 1'b0;
    repeat (3) step(32'h40, ADI, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(32'd4, ADI, 0, 0, 0, 0, 1);
    step(32'd8, ADD, 0, 0, 0, 0, 1);
    step(32'd12, ADI, 1, 1, 0, 0, 1);
    step(32'd12, ADI, 0, 1, 0, 0, 1);
    step(32'd16, ADD, 0, 0, 0, 0, 1);
    step(32'd20, ADD, 1, 0, 0, 0, 1);
    step(32'd24, ADD, 1, 5, 0, 0, 1);
    step(32'd28, LUI, 0, 0, 0, 0, 1);
    step(32'd32, LUI, 1, 0, 0, 0, 1);
    step(32'd36, ADI, 1, 1, 0, 0, 1);
    step(32'd40, ADI, 0, 0, 1, 0, 1);
    step(32'd44, ADI, 0, 0, 0, 0, 1);
    step(32'd48, ADI, 0, 0, 0, 0, 1);
    step(32'd52, ADI, 0, 0, 1, 0, 1);
    step(32'd56, ADI, 0, 0, 0, 0, 1);
    step(32'd60, ADI, 0, 0, 1, 0, 1);
    step(32'd64, ADI, 0, 0, 0, 0, 1);
    step(32'd68, ADD, 0, 0, 0, 0, 1);
    step(32'd72, ADD, 0, 0, 0, 0, 1);
    step(32'd76, ADI, 1, 1, 1, 1, 1);
    step(32'd80, ADI, 0, 0, 0, 0, 1);
    step(32'd84, ADD, 0, 0, 0, 0, 1);
    repeat (4) step(32'd88, ADI, 0, 0, 0, 1, 1);
    step(32'd92, ADD, 0, 0, 0, 0, 1);
    step(32'd96, ADI, 1, 1, 0, 0, 1);
    step(32'd96, ADI, 1, 1, 1, 0, 0);
    step(32'd96, ADI, 0, 0, 0, 0, 1);
    pc = 32'h100;
    for (int i = 0; i < 2000; i++) begin
      ins = {7'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 3'($urandom),
             5'($urandom), ops[$urandom_range(0, 9)]};
      pc = pc + 32'd4;
      step(pc, ins, 1'($urandom), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 149) != 0));
    end
    repeat (3) @(negedge clk);
    total_cnt++;
    if (comb_q.size() == 0 && reg_q.size() == 0) pass_cnt++;
    else $display("FAIL drain got %0d/%0d left want 0/0",
                  comb_q.size(), reg_q.size());
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/if_to_id.md
Name: if_to_id

Overview:
- IF/ID pipeline register of the 5-stage RV32I pipeline. Sits directly upstream of the ID/EXE register and feeds the decoder and register file.
- Holds the fetched PC and instruction, and detects load-use hazards against the instruction currently in EXE.
- Stalls the PC and injects a bubble into the ID/EXE control bits when needed.
- Squashes wrong-path fetches for a configurable number of cycles after a taken branch.

Parameters:
- NOP_INSTR, 32'h00000013, instruction word loaded on flush/reset (addi x0,x0,0).
- FLUSH_CYCLES, 1, consecutive fetch slots squashed per taken branch (1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCIn  in  32  PC of the fetched instruction.
- InstrIn  in  32  fetched instruction word.
- ex_memread  in  1  Memread bit of the instruction now in EXE (ID/EXE MEM[1]).
- ex_rd  in  5  destination register of the instruction now in EXE.
- branch_taken  in  1  taken-branch/jump redirect from the resolving stage.
- ext_stall  in  1  fetch/memory wait; freezes this stage.
- PC  out  32  registered PC.
- Instr  out  32  registered instruction.
- valid  out  1  Instr is a real (non-squashed) instruction.
- pc_write  out  1  PC register enable (combinational).
- bubble  out  1  forces EXE/MEM/WB control inputs of ID/EXE to 0 (combinational).

Behaviour:
- Reset (rst=0, async): PC=0, Instr=NOP_INSTR, valid=0, flush_cnt=0. pc_write=1 and bubble=1 while reset is asserted. Reset mid-flush clears the count.
- Decode, internal:
  - rs1=Instr[19:15], rs2=Instr[24:20], opcode=Instr[6:0].
  - uses_rs1: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111.
  - uses_rs2: opcodes 0110011, 0100011, 1100011 only.
- Load-use hazard (hz), combinational:
  - hz = valid & ex_memread & (ex_rd!=0) & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
- Per-edge priority, highest first:
  1. branch_taken=1: Instr<=NOP_INSTR, valid<=0, PC<=PCIn, flush_cnt<=FLUSH_CYCLES-1. A taken branch during an active flush restarts the count. Overrides hz and ext_stall.
  2. ext_stall=1 or hz=1: hold PC, Instr, valid and flush_cnt.
  3. flush_cnt!=0: load PC<=PCIn, Instr<=NOP_INSTR, valid<=0, decrement flush_cnt.
  4. Otherwise: PC<=PCIn, Instr<=InstrIn, valid<=1.
- Combinational outputs:
  - pc_write = branch_taken | ~(ext_stall | hz).
  - bubble = branch_taken | ext_stall | hz | ~valid.
- Latency: one cycle IF->ID.
- A load-use stall lasts exactly one cycle: the bubble clears ex_memread next cycle.
- flush_cnt is 3 bits. FLUSH_CYCLES=1 squashes only the slot captured on the branch edge.
- ex_rd=0 never stalls. An invalid (squashed) Instr never stalls.

Optional Feature:
- Macro IF_TO_ID_STATS_EN.
- When defined, adds two outputs:
  - stall_count [31:0]: increments on each edge with hz=1 and branch_taken=0.
  - flush_count [31:0]: increments on each edge with branch_taken=1.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=0 3 cycles, release -> PC=0, Instr=32'h00000013, valid=0. First edge after release with PCIn=4, InstrIn=32'h00500093 -> PC=4, valid=1.
- Load-use: Instr=add x3,x1,x2 (32'h002081B3), ex_memread=1, ex_rd=1 -> pc_write=0, bubble=1, regs held 1 cycle. Next cycle ex_memread=0 -> pc_write=1, new instruction loads.
- No hazard: the same Instr with ex_rd=0, then with ex_rd=5 -> pc_write=1, bubble=0. LUI x1 (32'h000010B7) with ex_rd=0 and ex_rd=1 -> no stall.
- Flush with FLUSH_CYCLES=2: branch_taken pulse while valid=1 -> valid=0 for 2 edges with Instr=NOP_INSTR, then valid=1. A second branch_taken during the count -> 2 more squashed slots.
- Simultaneous: branch_taken=1 with hz=1 and ext_stall=1 -> flush wins, pc_write=1, bubble=1. ext_stall held 4 cycles -> PC/Instr unchanged, pc_write=0.
- IF_TO_ID_STATS_EN: 3 load-use stalls and 2 branches -> stall_count=3, flush_count=2. Async reset mid-run -> both 0 immediately.
